// File: rtl/aes_core_sched.sv
// Round-robin two-requester scheduler feeding a shared combinational AES core with a multicycle settle budget.
// Optional performance counters are enabled by defining AES_SCHED_PERF_EN.
module aes_core_sched #(
    parameter int N        = 128,
    parameter int Nr       = 10,
    parameter int Nk       = 4,
    parameter int CORE_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [127:0]   req0_data,
    input  logic [N-1:0]   req0_key,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [127:0]   req1_data,
    input  logic [N-1:0]   req1_key,
    output logic [127:0]   core_in,
    output logic [N-1:0]   core_key,
    input  logic [127:0]   core_out,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [127:0]   rsp_data,
    output logic           rsp_id,
    output logic           busy
`ifdef AES_SCHED_PERF_EN
    ,
    output logic [31:0]    done_cnt0,
    output logic [31:0]    done_cnt1,
    output logic [31:0]    stall_cnt
`endif
);

    // An inconsistent key/round configuration falls back to the longest settle budget.
    localparam bit CFG_OK = (N == 32 * Nk) && (Nr == Nk + 6) && (CORE_LAT >= 1) && (CORE_LAT <= 15);
    localparam logic [3:0] LAT_LOAD = CFG_OK ? 4'(CORE_LAT - 1) : 4'd14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_r;
    logic [3:0] cnt_r;
    logic       last_grant_r;
    logic       grant_s;
    logic       grant_valid_s;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_s       = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_valid_s = 1'b1;
            grant_s       = ~last_grant_r;
        end else if (req0_valid) begin
            grant_valid_s = 1'b1;
            grant_s       = 1'b0;
        end else if (req1_valid) begin
            grant_valid_s = 1'b1;
            grant_s       = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_s       = 1'b0;
        end
    end

    assign req0_ready = (state_r == IDLE) && grant_valid_s && !grant_s;
    assign req1_ready = (state_r == IDLE) && grant_valid_s &&  grant_s;

    // Scheduler FSM: accept a block, let the core settle, then hold the response until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            last_grant_r <= 1'b1;
            core_in      <= '0;
            core_key     <= '0;
            rsp_data     <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        core_in      <= grant_s ? req1_data : req0_data;
                        core_key     <= grant_s ? req1_key  : req0_key;
                        rsp_id       <= grant_s;
                        last_grant_r <= grant_s;
                        cnt_r        <= LAT_LOAD;
                        state_r      <= WAIT;
                        busy         <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        rsp_data  <= core_out;
                        rsp_valid <= 1'b1;
                        state_r   <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

`ifdef AES_SCHED_PERF_EN
    // Per-requester completion counts and response backpressure cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt0 <= 32'd0;
            done_cnt1 <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if ((state_r == RESP) && rsp_ready && !rsp_id) begin
                done_cnt0 <= done_cnt0 + 32'd1;
            end
            if ((state_r == RESP) && rsp_ready && rsp_id) begin
                done_cnt1 <= done_cnt1 + 32'd1;
            end
            if ((state_r == RESP) && !rsp_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes_core_sched.sv
// Bench for aes_core_sched: AES-128 core model, transaction-level scheduler model, FIPS-197 vectors.
// Three instances (settle budgets 2, 1 and 15) share the requester and response-ready inputs.
module tb_aes_core_sched;

    localparam int CORE_LAT = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid, req1_valid, rsp_ready;
    logic [127:0] req0_data, req1_data, req0_key, req1_key;

    logic         rdy0 [3];
    logic         rdy1 [3];
    logic         rv   [3];
    logic         rid  [3];
    logic         bsy  [3];
    logic [127:0] cin  [3];
    logic [127:0] ckey [3];
    logic [127:0] cout [3];
    logic [127:0] rdata[3];
`ifdef AES_SCHED_PERF_EN
    logic [31:0]  dc0  [3];
    logic [31:0]  dc1  [3];
    logic [31:0]  stl  [3];
`endif

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] inv;
        p   = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p   = gmul(p, p);
            inv = gmul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox(s[(i%4) + 4*(((i/4) + (i%4)) % 4)]);
            for (int c = 0; c < 4; c++) begin
                if (r != 10) begin
                    s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
                    s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? CORE_LAT : ((g == 1) ? 1 : 15);
        aes_core_sched #(.N(128), .Nr(10), .Nk(4), .CORE_LAT(LAT)) u_dut (
            .clk(clk), .rst(rst),
            .req0_valid(req0_valid), .req0_ready(rdy0[g]), .req0_data(req0_data), .req0_key(req0_key),
            .req1_valid(req1_valid), .req1_ready(rdy1[g]), .req1_data(req1_data), .req1_key(req1_key),
            .core_in(cin[g]), .core_key(ckey[g]), .core_out(cout[g]),
            .rsp_valid(rv[g]), .rsp_ready(rsp_ready), .rsp_data(rdata[g]), .rsp_id(rid[g]),
            .busy(bsy[g])
`ifdef AES_SCHED_PERF_EN
            , .done_cnt0(dc0[g]), .done_cnt1(dc1[g]), .stall_cnt(stl[g])
`endif
        );
        assign cout[g] = aes128(cin[g], ckey[g]);
    end

    int           total = 0;
    int           passed = 0;
    int           failed = 0;
    int           cycle = 0;
    logic         m_idle, m_last, m_id, hold;
    int           m_acc, m_done0, m_done1, n_acc, obs_rv;
    logic [127:0] m_pt, m_key, m_ct, obs_data;
    logic         obs_id;
    int           grants[$];
    int           accs[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare the main instance against the model, then advance the model.
    task automatic tick();
        logic e0, e1, exp_rv, hs, o0, o1;
        #1;
        e0     = m_idle && req0_valid && (!req1_valid || m_last);
        e1     = m_idle && req1_valid && (!req0_valid || !m_last);
        exp_rv = !m_idle && (cycle >= m_acc + CORE_LAT);
        o0     = rdy0[0] && req0_valid;
        o1     = rdy1[0] && req1_valid;
        chk("req0_ready", rdy0[0], e0);
        chk("req1_ready", rdy1[0], e1);
        chk("rsp_valid", rv[0], exp_rv);
        chk("busy", bsy[0], !m_idle);
        if (!m_idle) begin
            chk("core_in", cin[0], m_pt);
            chk("core_key", ckey[0], m_key);
        end
        if (exp_rv) begin
            chk("rsp_data", rdata[0], m_ct);
            chk("rsp_id", rid[0], m_id);
        end
        hs = exp_rv && rsp_ready;
        @(posedge clk);
        cycle++;
        if (o0 || o1) begin
            grants.push_back(o1 ? 1 : 0);
            accs.push_back(cycle);
        end
        if (e0 || e1) begin
            m_idle = 1'b0;
            m_acc  = cycle;
            m_id   = e1;
            m_last = e1;
            m_pt   = e1 ? req1_data : req0_data;
            m_key  = e1 ? req1_key  : req0_key;
            m_ct   = aes128(m_pt, m_key);
            n_acc++;
            obs_rv = -1;
        end
        if (hs) begin
            m_idle = 1'b1;
            if (m_id) m_done1++;
            else m_done0++;
        end
        #1;
        if ((e0 || e1) && !hold) begin
            if (e1) req1_valid = 1'b0;
            else req0_valid = 1'b0;
        end
        if (rv[0] && obs_rv < 0 && !m_idle) begin
            obs_rv   = cycle;
            obs_data = rdata[0];
            obs_id   = rid[0];
        end
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        rst        = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_busy%0d", g), bsy[g], 1'b0);
            chk($sformatf("rst_rsp_valid%0d", g), rv[g], 1'b0);
        end
        chk("rst_core_in", cin[0], 128'h0);
        chk("rst_core_key", ckey[0], 128'h0);
        chk("rst_rsp_data", rdata[0], 128'h0);
        chk("rst_rsp_id", rid[0], 1'b0);
`ifdef AES_SCHED_PERF_EN
        chk("rst_done_cnt0", dc0[0], 32'h0);
        chk("rst_done_cnt1", dc1[0], 32'h0);
        chk("rst_stall_cnt", stl[0], 32'h0);
`endif
        m_idle  = 1'b1;
        m_last  = 1'b1;
        m_done0 = 0;
        m_done1 = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 40 && !m_idle; i++) tick();
        chk("drain_idle", bsy[0], 1'b0);
    endtask

    task automatic send(input logic id, input logic [127:0] pt, input logic [127:0] key,
                        input logic [127:0] ct, input string tag);
        int a0;
        if (id) begin
            req1_valid = 1'b1; req1_data = pt; req1_key = key;
        end else begin
            req0_valid = 1'b1; req0_data = pt; req0_key = key;
        end
        rsp_ready = 1'b1;
        a0 = n_acc;
        for (int i = 0; i < 8 && n_acc == a0; i++) tick();
        chk({tag, "_accepted"}, n_acc - a0, 1);
        for (int i = 0; i < 40 && !m_idle; i++) tick();
        chk({tag, "_latency"}, obs_rv - m_acc, CORE_LAT);
        chk({tag, "_data"}, obs_data, ct);
        chk({tag, "_id"}, obs_id, id);
    endtask

    initial begin
        int lat1, lat15;
        logic [127:0] d1, d15;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_data = '0; req1_data = '0; req0_key = '0; req1_key = '0;
        hold = 1'b0; n_acc = 0; obs_rv = -1; obs_data = '0; obs_id = 1'b0;
        m_acc = 0; m_id = 1'b0; m_pt = '0; m_key = '0; m_ct = '0;
        do_reset();

        send(1'b0, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
             128'h69c4e0d86a7b0430d8cdb78070b4c55a, "fips_c1");
        send(1'b1, 128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
             128'h3925841d02dc09fbdc118597196a0b32, "fips_b");

        // Both requesters held valid: alternating grants at the minimum issue period.
        grants.delete();
        accs.delete();
        hold = 1'b1;
        req0_valid = 1'b1; req0_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        req0_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
        req1_valid = 1'b1; req1_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        req1_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
        rsp_ready  = 1'b1;
        for (int i = 0; i < 80 && grants.size() < 4; i++) tick();
        hold = 1'b0;
        drain();
        chk("rr_count", grants.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) chk($sformatf("rr_grant%0d", i), grants[i], i % 2);
        end
        for (int i = 1; i < 4; i++) begin
            if (i < accs.size()) chk($sformatf("rr_spacing%0d", i), accs[i] - accs[i-1], CORE_LAT + 2);
        end

        // Reset one cycle after an accept drops the block; the next tie goes to requester 0.
        req0_valid = 1'b1; req0_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        tick();
        do_reset();
        grants.delete();
        req0_valid = 1'b1; req1_valid = 1'b1;
        tick();
        chk("tie_after_reset", (grants.size() == 1) ? grants[0] : -1, 0);
        drain();

        // Backpressure: ten response-stall cycles while both requesters wait.
        req0_valid = 1'b1; req0_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        rsp_ready  = 1'b0;
        for (int i = 0; i < 40 && obs_rv < 0; i++) tick();
        chk("bp_rsp_seen", obs_rv >= 0, 1'b1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) tick();
`ifdef AES_SCHED_PERF_EN
        chk("bp_stall_cnt", stl[0], 32'd10);
`endif
        drain();

        // Random traffic, withdrawals and response backpressure.
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid && $urandom_range(0, 3) == 0) begin
                req0_valid = 1'b1;
                req0_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
                req0_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
            end else if (req0_valid && $urandom_range(0, 15) == 0) begin
                req0_valid = 1'b0;
            end
            if (!req1_valid && $urandom_range(0, 3) == 0) begin
                req1_valid = 1'b1;
                req1_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
                req1_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
            end else if (req1_valid && $urandom_range(0, 15) == 0) begin
                req1_valid = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain();
`ifdef AES_SCHED_PERF_EN
        chk("done_cnt0", dc0[0], m_done0);
        chk("done_cnt1", dc1[0], m_done1);
`endif

        // Settle budgets of 1 and 15 on the Appendix C.1 vector.
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 128'h00112233445566778899aabbccddeeff;
        req0_key   = 128'h000102030405060708090a0b0c0d0e0f;
        rsp_ready  = 1'b1;
        tick();
        lat1 = -1; lat15 = -1; d1 = '0; d15 = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rv[1] && lat1 < 0) begin lat1 = cycle - m_acc; d1 = rdata[1]; end
            if (rv[2] && lat15 < 0) begin lat15 = cycle - m_acc; d15 = rdata[2]; end
        end
        chk("lat1_latency", lat1, 1);
        chk("lat1_data", d1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("lat15_latency", lat15, 15);
        chk("lat15_data", d15, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
